// File: rtl/icache_rvc_nway.sv
// N-way set-associative RV32IC instruction cache; serves halfword-aligned 16/32-bit fetches, including line-crossing ones.
// Replacement: define ICACHE_LRU_EN for per-set tree pseudo-LRU, otherwise one global round-robin counter.
module icache_rvc_nway #(
    parameter int unsigned WAYS   = 2,
    parameter int unsigned SETS   = 4,
    parameter int unsigned ADDR_W = 31
) (
    input  logic              clk,
    input  logic              proc_reset_n_i,
    input  logic              proc_read_i,
    input  logic              proc_flush_i,
    input  logic [ADDR_W-1:0] proc_addr_i,
    output logic [31:0]       proc_rdata_o,
    output logic              proc_stall_o,
    output logic              mem_read_o,
    output logic [ADDR_W-4:0] mem_addr_o,
    input  logic [127:0]      mem_rdata_i,
    input  logic              mem_ready_i
);
    localparam int unsigned LINE_W = ADDR_W - 3;
    localparam int unsigned IDX_W  = $clog2(SETS);
    localparam int unsigned TAG_W  = LINE_W - IDX_W;
    localparam int unsigned WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int unsigned PLRU_W = (WAYS > 1) ? WAYS - 1 : 1;

    typedef enum logic [1:0] {IDLE, SPAN, ALLOC, FLUSH} state_t;

    state_t            state_q;
    logic [1:0]        rst_sync_q;
    logic              rst_n;
    logic              valid_q [SETS][WAYS];
    logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
    logic [127:0]      data_q  [SETS][WAYS];
    logic [15:0]       half_q;
    logic              ret_span_q;
    logic              flush_pend_q;
    logic [IDX_W-1:0]  cnt_q;

    logic [LINE_W-1:0] line_a, look_line;
    logic [IDX_W-1:0]  look_idx, fill_idx;
    logic [TAG_W-1:0]  look_tag, fill_tag;
    logic              hit, fill, touch;
    logic [WAY_W-1:0]  hit_way, vict_way, repl_way;
    logic [127:0]      hit_line;
    logic [15:0]       hws [8];
    logic [15:0]       hw_lo, hw_hi;
    logic [2:0]        off;
    logic              compressed, span_needed;

    always_ff @(posedge clk or negedge proc_reset_n_i) begin
        if (!proc_reset_n_i) rst_sync_q <= '0;
        else                 rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    // SPAN re-uses the single lookup port on the following line.
    assign line_a    = proc_addr_i[ADDR_W-1:3];
    assign look_line = (state_q == SPAN) ? line_a + LINE_W'(1) : line_a;
    assign look_idx  = look_line[IDX_W-1:0];
    assign look_tag  = look_line[LINE_W-1:IDX_W];
    assign fill_idx  = mem_addr_o[IDX_W-1:0];
    assign fill_tag  = mem_addr_o[LINE_W-1:IDX_W];
    assign off       = proc_addr_i[2:0];

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (valid_q[look_idx][w] && tag_q[look_idx][w] == look_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    always_comb begin
        vict_way = repl_way;
        for (int unsigned w = WAYS; w > 0; w--) begin
            if (!valid_q[fill_idx][w-1]) vict_way = WAY_W'(w - 1);
        end
    end

    assign hit_line = data_q[look_idx][hit_way];
    always_comb begin
        for (int unsigned k = 0; k < 8; k++) hws[k] = hit_line[16*k +: 16];
    end
    assign hw_lo       = hws[off];
    assign hw_hi       = hws[off + 3'd1];
    assign compressed  = hw_lo[1:0] != 2'b11;
    assign span_needed = hit && off == 3'd7 && !compressed;

    assign fill  = state_q == ALLOC && mem_ready_i;
    assign touch = (state_q == IDLE && proc_read_i && !proc_flush_i && !flush_pend_q && hit) ||
                   (state_q == SPAN && hit);

`ifdef ICACHE_LRU_EN
    logic [PLRU_W-1:0] plru_q [SETS];
    logic [PLRU_W-1:0] plru_hit_nxt, plru_fill_nxt;

    if (WAYS == 4) begin : g_plru4
        // Bit 0 picks the half, bits 1/2 pick within the left/right half; 0 points left.
        function automatic logic [2:0] touch4(input logic [2:0] t, input logic [1:0] w);
            touch4    = t;
            touch4[0] = ~w[1];
            if (w[1]) touch4[2] = ~w[0];
            else      touch4[1] = ~w[0];
        endfunction
        assign repl_way      = plru_q[fill_idx][0] ? {1'b1, plru_q[fill_idx][2]} : {1'b0, plru_q[fill_idx][1]};
        assign plru_hit_nxt  = touch4(plru_q[look_idx], hit_way);
        assign plru_fill_nxt = touch4(plru_q[fill_idx], vict_way);
    end else if (WAYS == 2) begin : g_plru2
        assign repl_way      = plru_q[fill_idx];
        assign plru_hit_nxt  = ~hit_way;
        assign plru_fill_nxt = ~vict_way;
    end else begin : g_plru1
        assign repl_way      = '0;
        assign plru_hit_nxt  = '0;
        assign plru_fill_nxt = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned s = 0; s < SETS; s++) plru_q[s] <= '0;
        end else if (fill) begin
            plru_q[fill_idx] <= plru_fill_nxt;
        end else if (touch) begin
            plru_q[look_idx] <= plru_hit_nxt;
        end
    end
`else
    logic [WAY_W-1:0] rr_q;

    assign repl_way = (WAYS > 1) ? rr_q : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    rr_q <= '0;
        else if (fill) rr_q <= rr_q + WAY_W'(1);
    end
`endif

    always_ff @(posedge clk) begin
        if (fill) begin
            data_q[fill_idx][vict_way] <= mem_rdata_i;
            tag_q[fill_idx][vict_way]  <= fill_tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            for (int unsigned s = 0; s < SETS; s++)
                for (int unsigned w = 0; w < WAYS; w++) valid_q[s][w] <= 1'b0;
            half_q       <= '0;
            ret_span_q   <= 1'b0;
            flush_pend_q <= 1'b0;
            cnt_q        <= '0;
            mem_read_o   <= 1'b0;
            mem_addr_o   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (proc_flush_i || flush_pend_q) begin
                        state_q      <= FLUSH;
                        cnt_q        <= '0;
                        flush_pend_q <= 1'b0;
                    end else if (proc_read_i) begin
                        if (!hit) begin
                            state_q    <= ALLOC;
                            mem_read_o <= 1'b1;
                            mem_addr_o <= line_a;
                            ret_span_q <= 1'b0;
                        end else if (span_needed) begin
                            half_q  <= hw_lo;
                            state_q <= SPAN;
                        end
                    end
                end
                SPAN: begin
                    if (proc_flush_i) flush_pend_q <= 1'b1;
                    if (!hit) begin
                        state_q    <= ALLOC;
                        mem_read_o <= 1'b1;
                        mem_addr_o <= look_line;
                        ret_span_q <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                ALLOC: begin
                    if (proc_flush_i) flush_pend_q <= 1'b1;
                    if (mem_ready_i) begin
                        valid_q[fill_idx][vict_way] <= 1'b1;
                        mem_read_o <= 1'b0;
                        ret_span_q <= 1'b0;
                        state_q    <= (ret_span_q && proc_read_i) ? SPAN : IDLE;
                    end
                end
                default: begin
                    for (int unsigned w = 0; w < WAYS; w++) valid_q[cnt_q][w] <= 1'b0;
                    cnt_q <= cnt_q + IDX_W'(1);
                    if (cnt_q == IDX_W'(SETS - 1)) state_q <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        proc_rdata_o = '0;
        proc_stall_o = 1'b0;
        if (rst_n) begin
            case (state_q)
                IDLE: begin
                    proc_stall_o = proc_read_i && (!hit || span_needed || proc_flush_i || flush_pend_q);
                    if (hit) proc_rdata_o = compressed ? {16'h0, hw_lo} : {hw_hi, hw_lo};
                end
                SPAN: begin
                    proc_stall_o = !hit;
                    if (hit) proc_rdata_o = {hws[0], half_q};
                end
                default: proc_stall_o = 1'b1;
            endcase
        end
    end
endmodule

// File: tb/tb_icache_rvc_nway.sv
// Directed self-checking bench for icache_rvc_nway (WAYS=2, SETS=4, memory latency 3).
module tb_icache_rvc_nway;
    localparam int LAT = 3;

    logic         clk = 1'b0;
    logic         proc_reset_n_i = 1'b0;
    logic         proc_read_i = 1'b0;
    logic         proc_flush_i = 1'b0;
    logic [30:0]  proc_addr_i = '0;
    logic [31:0]  proc_rdata_o;
    logic         proc_stall_o;
    logic         mem_read_o;
    logic [27:0]  mem_addr_o;
    logic [127:0] mem_rdata_i = '0;
    logic         mem_ready_i = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    icache_rvc_nway #(.WAYS(2), .SETS(4), .ADDR_W(31)) dut (
        .clk(clk), .proc_reset_n_i(proc_reset_n_i), .proc_read_i(proc_read_i),
        .proc_flush_i(proc_flush_i), .proc_addr_i(proc_addr_i), .proc_rdata_o(proc_rdata_o),
        .proc_stall_o(proc_stall_o), .mem_read_o(mem_read_o), .mem_addr_o(mem_addr_o),
        .mem_rdata_i(mem_rdata_i), .mem_ready_i(mem_ready_i)
    );

    always #5 clk = ~clk;

    // Halfword k of line la: non-compressed pattern, except one compressed halfword in line 0x2.
    function automatic logic [15:0] mem_hw(input logic [27:0] la, input int k);
        logic [2:0] kk;
        kk = 3'(k);
        if (la == 28'h2 && k == 6) return 16'h4501;
        return {la[7:0], 1'b0, kk, 4'h7};
    endfunction

    function automatic logic [127:0] mem_line(input logic [27:0] la);
        logic [127:0] l;
        for (int k = 0; k < 8; k++) l[16*k +: 16] = mem_hw(la, k);
        return l;
    endfunction

    // Holds a fetch until stall drops, serving refills with latency LAT; optionally pulses flush in the first ALLOC cycle.
    task automatic fetch(input logic [30:0] a, input bit flush_alloc, output logic [31:0] d,
                         output int stalls, output int refills, output logic [27:0] maddr);
        int acnt;
        bit done;
        logic [27:0] hold;
        proc_addr_i = a;
        proc_read_i = 1'b1;
        stalls = 0; refills = 0; acnt = 0; done = 0; maddr = '0; d = '0; hold = '0;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            if (!proc_stall_o) begin
                d = proc_rdata_o;
                done = 1;
            end else begin
                stalls++;
                if (mem_read_o) begin
                    acnt++;
                    if (acnt == 1) hold = mem_addr_o;
                    else begin
                        n_cmp++;
                        if (mem_addr_o !== hold) begin
                            n_err++;
                            $display("FAIL mem_addr_stable: got %h expected %h", mem_addr_o, hold);
                        end
                    end
                    maddr = mem_addr_o;
                    if (flush_alloc && acnt == 1 && refills == 0) proc_flush_i = 1'b1;
                    if (acnt == LAT + 1) begin
                        mem_rdata_i = mem_line(mem_addr_o);
                        mem_ready_i = 1'b1;
                        refills++;
                        acnt = 0;
                    end
                end
                @(posedge clk);
                #1;
                mem_ready_i = 1'b0;
                proc_flush_i = 1'b0;
            end
        end
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL fetch_timeout: addr %h still stalled after 200 cycles", a);
        end
        @(posedge clk);
        #1;
        proc_read_i = 1'b0;
    endtask

    task automatic do_reset();
        proc_reset_n_i = 1'b0;
        proc_read_i = 1'b0;
        proc_flush_i = 1'b0;
        mem_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 proc_reset_n_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        proc_reset_n_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp += 4;
        if (mem_read_o !== 1'b0) begin n_err++; $display("FAIL reset_mem_read: got %b expected 0", mem_read_o); end
        if (mem_addr_o !== 28'h0) begin n_err++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr_o); end
        if (proc_rdata_o !== 32'h0) begin n_err++; $display("FAIL reset_rdata: got %h expected 0", proc_rdata_o); end
        if (proc_stall_o !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b expected 0", proc_stall_o); end
        do_reset();
    endtask

    task automatic test_cold_miss();
        logic [31:0] d; int st, rf; logic [27:0] ma;
        fetch(31'h10, 0, d, st, rf, ma);
        n_cmp += 4;
        if (d !== 32'h02170207) begin n_err++; $display("FAIL cold_data: got %h expected 02170207", d); end
        if (st != 5) begin n_err++; $display("FAIL cold_stalls: got %0d expected 5", st); end
        if (rf != 1) begin n_err++; $display("FAIL cold_refills: got %0d expected 1", rf); end
        if (ma !== 28'h2) begin n_err++; $display("FAIL cold_mem_addr: got %h expected 2", ma); end
        fetch(31'h10, 0, d, st, rf, ma);
        n_cmp += 2;
        if (d !== 32'h02170207) begin n_err++; $display("FAIL rehit_data: got %h expected 02170207", d); end
        if (st != 0) begin n_err++; $display("FAIL rehit_stalls: got %0d expected 0", st); end
    endtask

    task automatic test_compressed();
        logic [31:0] d; int st, rf; logic [27:0] ma;
        fetch(31'h16, 0, d, st, rf, ma);
        n_cmp += 2;
        if (d !== 32'h00004501) begin n_err++; $display("FAIL rvc_data: got %h expected 00004501", d); end
        if (st != 0) begin n_err++; $display("FAIL rvc_stalls: got %0d expected 0", st); end
    endtask

    task automatic test_span();
        logic [31:0] d; int st, rf; logic [27:0] ma;
        fetch(31'h2F, 0, d, st, rf, ma);
        n_cmp += 4;
        if (d !== 32'h06070577) begin n_err++; $display("FAIL span_data: got %h expected 06070577", d); end
        if (st != 11) begin n_err++; $display("FAIL span_stalls: got %0d expected 11", st); end
        if (rf != 2) begin n_err++; $display("FAIL span_refills: got %0d expected 2", rf); end
        if (ma !== 28'h6) begin n_err++; $display("FAIL span_mem_addr: got %h expected 6", ma); end
        fetch(31'h2F, 0, d, st, rf, ma);
        n_cmp += 2;
        if (d !== 32'h06070577) begin n_err++; $display("FAIL span_hit_data: got %h expected 06070577", d); end
        if (st != 1) begin n_err++; $display("FAIL span_hit_stalls: got %0d expected 1", st); end
        fetch(31'h7FFFFFFF, 0, d, st, rf, ma);
        n_cmp += 3;
        if (d !== 32'h0007FF77) begin n_err++; $display("FAIL wrap_data: got %h expected 0007ff77", d); end
        if (rf != 2) begin n_err++; $display("FAIL wrap_refills: got %0d expected 2", rf); end
        if (ma !== 28'h0) begin n_err++; $display("FAIL wrap_mem_addr: got %h expected 0", ma); end
    endtask

    task automatic test_replacement();
        logic [31:0] d; int st, rf, exp_rf; logic [27:0] ma;
        do_reset();
        fetch(31'h00, 0, d, st, rf, ma);
        fetch(31'h20, 0, d, st, rf, ma);
        fetch(31'h00, 0, d, st, rf, ma);
        n_cmp++;
        if (st != 0) begin n_err++; $display("FAIL repl_hit0_stalls: got %0d expected 0", st); end
        fetch(31'h40, 0, d, st, rf, ma);
        n_cmp++;
        if (d !== 32'h08170807) begin n_err++; $display("FAIL repl_fill8_data: got %h expected 08170807", d); end
`ifdef ICACHE_LRU_EN
        exp_rf = 1;
`else
        exp_rf = 0;
`endif
        fetch(31'h20, 0, d, st, rf, ma);
        n_cmp += 2;
        if (rf != exp_rf) begin n_err++; $display("FAIL repl_probe4_refills: got %0d expected %0d", rf, exp_rf); end
        if (d !== 32'h04170407) begin n_err++; $display("FAIL repl_probe4_data: got %h expected 04170407", d); end
    endtask

    task automatic test_flush();
        logic [31:0] d; int st, rf; logic [27:0] ma;
        do_reset();
        fetch(31'h10, 1, d, st, rf, ma);
        n_cmp += 3;
        if (d !== 32'h02170207) begin n_err++; $display("FAIL flush_alloc_data: got %h expected 02170207", d); end
        if (st != 15) begin n_err++; $display("FAIL flush_alloc_stalls: got %0d expected 15", st); end
        if (rf != 2) begin n_err++; $display("FAIL flush_alloc_refills: got %0d expected 2", rf); end
        proc_flush_i = 1'b1;
        @(posedge clk);
        #1 proc_flush_i = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        fetch(31'h10, 0, d, st, rf, ma);
        n_cmp += 2;
        if (rf != 1) begin n_err++; $display("FAIL flush_idle_refills: got %0d expected 1", rf); end
        if (st != 5) begin n_err++; $display("FAIL flush_idle_stalls: got %0d expected 5", st); end
    endtask

    task automatic test_reset_alloc();
        logic [31:0] d; int st, rf; logic [27:0] ma; bit seen;
        seen = 0;
        proc_addr_i = 31'h48;
        proc_read_i = 1'b1;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (mem_read_o) seen = 1;
        end
        n_cmp++;
        if (!seen) begin n_err++; $display("FAIL rst_alloc_enter: got no mem_read_o, expected refill request"); end
        #2 proc_reset_n_i = 1'b0;
        #1;
        n_cmp++;
        if (mem_read_o !== 1'b0) begin n_err++; $display("FAIL rst_alloc_mem_read: got %b expected 0", mem_read_o); end
        proc_read_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 proc_reset_n_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        fetch(31'h10, 0, d, st, rf, ma);
        n_cmp += 2;
        if (rf != 1) begin n_err++; $display("FAIL rst_alloc_refetch_refills: got %0d expected 1", rf); end
        if (d !== 32'h02170207) begin n_err++; $display("FAIL rst_alloc_refetch_data: got %h expected 02170207", d); end
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_compressed();
        test_span();
        test_replacement();
        test_flush();
        test_reset_alloc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
